mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/arb_rr2.sv | 22 ++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arbiter_pkg;

  // Arbiter FSM: at most one memory access in flight.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StWait = 1'b1
  } arb_state_e;

  // Legal range of the memory read latency parameter.
  localparam int unsigned MemLatMin = 1;
  localparam int unsigned MemLatMax = 4;

  // Latency countdown width; holds MemLatMax-1.
  localparam int unsigned CntW = 2;

  // Countdown start value so that ack lands exactly lat cycles after grant.
  function automatic logic [CntW-1:0] lat_to_cnt(input int unsigned lat);
    return CntW'(lat - 1);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker.
// A lone requester always wins; on a tie the requester not granted last wins.
module arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       winner_o,
  output logic       valid_o
);

  // Pick the winner from the current request vector and the last grant.
  always_comb begin
    valid_o  = |req_i;
    winner_o = 1'b0;
    unique case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = ~last_i;
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with a fixed-latency memory port.
// Grants are issued combinationally from IDLE; the access then waits MEM_LAT
// cycles before the owner sees its one-cycle ack (and read data for reads).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  // Requester 0: CPU controller
  input  logic              r0_req_i,
  input  logic              r0_we_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_wdata_i,
  output logic              r0_gnt_o,
  output logic              r0_ack_o,
  output logic [DATA_W-1:0] r0_rdata_o,
  // Requester 1: loader/debug
  input  logic              r1_req_i,
  input  logic              r1_we_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_wdata_i,
  output logic              r1_gnt_o,
  output logic              r1_ack_o,
  output logic [DATA_W-1:0] r1_rdata_o,
  // Memory port
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  if (MEM_LAT < MemLatMin || MEM_LAT > MemLatMax) begin : g_bad_mem_lat
    $error("mem_arbiter: MEM_LAT must lie in 1..4");
  end

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;  // requester granted most recently
  logic            sel_q, sel_d;    // owner of the outstanding access
  logic            we_q, we_d;      // outstanding access is a write
  logic            winner;
  logic            arb_valid;
  logic            grant;
  logic            ack;

  arb_rr2 u_arb (
    .req_i    ({r1_req_i, r0_req_i}),
    .last_i   (last_q),
    .winner_o (winner),
    .valid_o  (arb_valid)
  );

  // Next-state logic: grant from IDLE, count down the latency in WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    we_d    = we_q;
    grant   = 1'b0;
    ack     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Reset is asynchronous, so a held request must not leak a grant
        // through the combinational path while reset is still asserted.
        if (arb_valid && !reset_i) begin
          grant   = 1'b1;
          state_d = StWait;
          cnt_d   = lat_to_cnt(MEM_LAT);
          last_d  = winner;
          sel_d   = winner;
          we_d    = winner ? r1_we_i : r0_we_i;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          ack     = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; last-grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
    end
  end

  // Output steering: memory port from the winner, ack/rdata to the owner.
  always_comb begin
    r0_gnt_o    = 1'b0;
    r1_gnt_o    = 1'b0;
    r0_ack_o    = 1'b0;
    r1_ack_o    = 1'b0;
    r0_rdata_o  = '0;
    r1_rdata_o  = '0;
    mem_en_o    = grant;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (grant) begin
      if (winner) begin
        r1_gnt_o    = 1'b1;
        mem_we_o    = r1_we_i;
        mem_addr_o  = r1_addr_i;
        mem_wdata_o = r1_wdata_i;
      end else begin
        r0_gnt_o    = 1'b1;
        mem_we_o    = r0_we_i;
        mem_addr_o  = r0_addr_i;
        mem_wdata_o = r0_wdata_i;
      end
    end
    if (ack) begin
      if (sel_q) begin
        r1_ack_o   = 1'b1;
        r1_rdata_o = we_q ? '0 : mem_rdata_i;
      end else begin
        r0_ack_o   = 1'b1;
        r0_rdata_o = we_q ? '0 : mem_rdata_i;
      end
    end
  end

  assign busy_o = (state_q == StWait);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a cycle-level reference model predicts
// grants and acks from the arbitration rules, a negedge monitor compares.
// A second instance with MEM_LAT=1 runs a fixed streaming pattern alongside.
module tb_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic          reset;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r0_ack, r1_gnt, r1_ack;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // MEM_LAT=1 instance signals
  logic          l1_reset;
  logic          l1_gnt0, l1_ack0, l1_gnt1, l1_ack1, l1_busy, l1_mem_en, l1_mem_we;
  logic [DW-1:0] l1_rdata0, l1_rdata1, l1_mem_wdata;
  logic [AW-1:0] l1_mem_addr;
  logic          l1_phase;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
    .clk_i(clk), .reset_i(reset),
    .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
    .r0_gnt_o(r0_gnt), .r0_ack_o(r0_ack), .r0_rdata_o(r0_rdata),
    .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
    .r1_gnt_o(r1_gnt), .r1_ack_o(r1_ack), .r1_rdata_o(r1_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut_lat1 (
    .clk_i(clk), .reset_i(l1_reset),
    .r0_req_i(1'b1), .r0_we_i(1'b0), .r0_addr_i(32'h44), .r0_wdata_i(32'h0),
    .r0_gnt_o(l1_gnt0), .r0_ack_o(l1_ack0), .r0_rdata_o(l1_rdata0),
    .r1_req_i(1'b0), .r1_we_i(1'b0), .r1_addr_i(32'h0), .r1_wdata_i(32'h0),
    .r1_gnt_o(l1_gnt1), .r1_ack_o(l1_ack1), .r1_rdata_o(l1_rdata1),
    .mem_en_o(l1_mem_en), .mem_we_o(l1_mem_we), .mem_addr_o(l1_mem_addr),
    .mem_wdata_o(l1_mem_wdata), .mem_rdata_i(32'hC0DE_0001), .busy_o(l1_busy)
  );

  // Power-up contents of the 64-word memory window.
  function automatic logic [DW-1:0] init_word(input int unsigned i);
    return (i == 16) ? 32'hDEAD_BEEF : {16'h1357, 8'(i), 8'(~i)};
  endfunction

  // Memory behind the DUT: read data appears LAT cycles after mem_en,
  // and junk is presented whenever no read is due.
  bit   [DW-1:0] mem [64];
  bit            written [64];
  logic [DW-1:0] rd_pipe [LAT];
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr[5:0]]     <= mem_wdata;
      written[mem_addr[5:0]] <= 1'b1;
    end
    if (mem_en && !mem_we)
      rd_pipe[0] <= written[mem_addr[5:0]] ? mem[mem_addr[5:0]] : init_word(mem_addr[5:0]);
    else
      rd_pipe[0] <= $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Scoreboard
  typedef struct {
    int            cyc;
    logic [1:0]    gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_exp_t;

  typedef struct {
    int            due;
    logic [1:0]    ack;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
  } ack_exp_t;

  gnt_exp_t gnt_q[$];
  ack_exp_t ack_q[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc    = 0;

  // Reference model state
  int            m_free = 0;
  bit            m_last = 1'b1;
  bit   [1:0]    m_gnt  = 2'b00;
  bit   [DW-1:0] m_mem [64];
  bit            m_written [64];

  // Next-cycle stimulus
  bit            nx_rst = 1'b0;
  bit   [1:0]    nx_req = 2'b00;
  bit   [1:0]    nx_we  = 2'b00;
  logic [AW-1:0] nx_addr [2];
  logic [DW-1:0] nx_wdata [2];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Predict this cycle's grant (and its later ack) from the applied inputs.
  task automatic model();
    bit            w;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd;
    int unsigned   idx;
    m_gnt = 2'b00;
    if (reset) begin
      gnt_q.delete();
      ack_q.delete();
      m_free = cyc + 1;
      m_last = 1'b1;
    end else if (cyc >= m_free && (r0_req || r1_req)) begin
      if (r0_req && r1_req) w = !m_last;
      else                  w = r1_req;
      we    = w ? r1_we : r0_we;
      addr  = w ? r1_addr : r0_addr;
      wdata = w ? r1_wdata : r0_wdata;
      idx   = int'(addr[5:0]);
      rd    = 32'h0;
      if (we) begin
        m_mem[idx]     = wdata;
        m_written[idx] = 1'b1;
      end else begin
        rd = m_written[idx] ? m_mem[idx] : init_word(idx);
      end
      gnt_q.push_back('{cyc: cyc, gnt: (w ? 2'b10 : 2'b01), we: we, addr: addr, wdata: wdata});
      ack_q.push_back('{due: cyc + int'(LAT), ack: (w ? 2'b10 : 2'b01),
                        rd0: (w ? 32'h0 : rd), rd1: (w ? rd : 32'h0)});
      m_free   = cyc + int'(LAT) + 1;
      m_last   = w;
      m_gnt[w] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    reset    = nx_rst;
    r0_req   = nx_req[0];
    r0_we    = nx_we[0];
    r0_addr  = nx_addr[0];
    r0_wdata = nx_wdata[0];
    r1_req   = nx_req[1];
    r1_we    = nx_we[1];
    r1_addr  = nx_addr[1];
    r1_wdata = nx_wdata[1];
    model();
  endtask

  task automatic set_req(input int n, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
    nx_req[n]   = 1'b1;
    nx_we[n]    = we;
    nx_addr[n]  = addr;
    nx_wdata[n] = wdata;
  endtask

  task automatic idle(input int n);
    nx_req = 2'b00;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: compare DUT outputs against the scoreboard away from the edge.
  always @(negedge clk) begin
    gnt_exp_t ge;
    ack_exp_t ae;
    logic     exp_busy;
    if (cyc > 0) begin
      if (reset) begin
        check("reset_outputs",
              192'({r0_gnt, r1_gnt, r0_ack, r1_ack, mem_en, mem_we, busy,
                    r0_rdata, r1_rdata, mem_addr, mem_wdata}), 192'(0));
      end else begin
        exp_busy = (ack_q.size() > 0) && (cyc > ack_q[0].due - int'(LAT));
        check("busy", 192'(busy), 192'(exp_busy));
        ge = '{cyc: cyc, gnt: 2'b00, we: 1'b0, addr: '0, wdata: '0};
        if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) ge = gnt_q.pop_front();
        check("grant", 192'({r1_gnt, r0_gnt, mem_en, mem_we, mem_addr, mem_wdata}),
              192'({ge.gnt, |ge.gnt, ge.we, ge.addr, ge.wdata}));
        ae = '{due: cyc, ack: 2'b00, rd0: '0, rd1: '0};
        if (ack_q.size() > 0 && ack_q[0].due == cyc) ae = ack_q.pop_front();
        check("ack", 192'({r1_ack, r0_ack, r1_rdata, r0_rdata}),
              192'({ae.ack, ae.rd1, ae.rd0}));
      end
      // MEM_LAT=1 with r0 always requesting: grant, ack, grant, ack, ...
      if (l1_reset) begin
        l1_phase <= 1'b0;
      end else begin
        check("lat1_stream",
              192'({l1_gnt0, l1_gnt1, l1_ack0, l1_ack1, l1_busy, l1_mem_en, l1_mem_we,
                    l1_mem_addr, l1_mem_wdata, l1_rdata0, l1_rdata1}),
              192'({!l1_phase, 1'b0, l1_phase, 1'b0, l1_phase, !l1_phase, 1'b0,
                    (l1_phase ? 32'h0 : 32'h44), 32'h0,
                    (l1_phase ? 32'hC0DE_0001 : 32'h0), 32'h0}));
        l1_phase <= ~l1_phase;
      end
    end
  end

  initial begin
    reset    = 1'b0;
    l1_reset = 1'b0;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    nx_addr[0] = '0; nx_addr[1] = '0; nx_wdata[0] = '0; nx_wdata[1] = '0;

    // Reset both instances
    nx_rst = 1'b1;
    tick();
    l1_reset = 1'b1;
    tick();
    nx_rst = 1'b0;
    tick();
    l1_reset = 1'b0;
    idle(1);

    // Single read of 0x10
    set_req(0, 1'b0, 32'h10, 32'h0);
    tick();
    idle(4);

    // Tie straight after reset, both held: grants alternate 0,1,0,1
    nx_rst = 1'b1;
    tick();
    nx_rst = 1'b0;
    set_req(0, 1'b0, 32'h3, 32'h0);
    set_req(1, 1'b0, 32'h4, 32'h0);
    for (int i = 0; i < 13; i++) begin
      tick();
      for (int n = 0; n < 2; n++)
        if (m_gnt[n]) set_req(n, 1'b0, 32'(i + n), 32'h0);
    end
    idle(3);

    // Write by r1, then read it back through r0
    set_req(1, 1'b1, 32'h20, 32'h1234_5678);
    tick();
    idle(3);
    set_req(0, 1'b0, 32'h20, 32'h0);
    tick();
    idle(3);

    // Reset one cycle into an access: no ack, next tie goes to r0
    set_req(0, 1'b0, 32'h10, 32'h0);
    tick();
    nx_req = 2'b00;
    nx_rst = 1'b1;
    tick();
    nx_rst = 1'b0;
    set_req(0, 1'b0, 32'h11, 32'h0);
    set_req(1, 1'b0, 32'h12, 32'h0);
    tick();
    idle(4);

    // r1 raised and dropped while r0 is outstanding: never granted
    set_req(0, 1'b0, 32'h5, 32'h0);
    tick();
    nx_req[0] = 1'b0;
    set_req(1, 1'b0, 32'h7, 32'h0);
    tick();
    idle(4);

    // Randomised traffic with withdrawals and occasional resets
    for (int k = 0; k < 3000; k++) begin
      nx_rst = ($urandom_range(0, 199) == 0);
      for (int n = 0; n < 2; n++) begin
        if (nx_req[n] && !m_gnt[n]) begin
          if ($urandom_range(0, 7) == 0) nx_req[n] = 1'b0;
        end else begin
          nx_req[n]   = 1'($urandom_range(0, 1));
          nx_we[n]    = 1'($urandom_range(0, 1));
          nx_addr[n]  = $urandom;
          nx_wdata[n] = $urandom;
        end
      end
      tick();
    end
    nx_rst = 1'b0;
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
